// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/load-store) arbiter for the single-ported MIPS16 memory.
// Grants one requester, holds its command until mem_ack or timeout, then pulses done.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RR_MODE = 0,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              req_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic              we_d,
  input  logic [DATA_W-1:0] wdata_d,
  output logic              gnt_i,
  output logic              gnt_d,
  output logic              done_i,
  output logic              done_d,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              err_sticky,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned     CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              last_d, last_d_nxt;   // last grant went to D
  logic              owner_d, owner_d_nxt; // current command belongs to D
  logic              win_i, win_d;
  logic              busy_nxt, mem_en_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, rdata_nxt;
  logic              done_i_nxt, done_d_nxt, err_nxt, err_sticky_nxt;

  assign gnt_i = win_i;
  assign gnt_d = win_d;

  // Next-state, grant and registered-output next values
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_d_nxt     = last_d;
    owner_d_nxt    = owner_d;
    win_i          = 1'b0;
    win_d          = 1'b0;
    busy_nxt       = busy;
    mem_en_nxt     = mem_en;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    done_i_nxt     = 1'b0;
    done_d_nxt     = 1'b0;
    rdata_nxt      = '0;
    err_nxt        = 1'b0;
    err_sticky_nxt = err_sticky;

    unique case (state)
      S_IDLE: begin
        if (!rst) begin
          // D wins unless both request in round-robin mode and D went last
          win_d = req_d && (!req_i || (RR_MODE == 0) || !last_d);
          win_i = req_i && !win_d;
        end
        if (win_i || win_d) begin
          state_nxt     = S_BUSY;
          cnt_nxt       = '0;
          owner_d_nxt   = win_d;
          last_d_nxt    = win_d;
          busy_nxt      = 1'b1;
          mem_en_nxt    = 1'b1;
          mem_we_nxt    = win_d && we_d;
          mem_addr_nxt  = win_d ? addr_d : addr_i;
          mem_wdata_nxt = win_d ? wdata_d : '0;
        end
      end

      S_BUSY: begin
        if (mem_ack || (cnt == CNT_LAST)) begin
          state_nxt     = S_DONE;
          mem_en_nxt    = 1'b0;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = '0;
          mem_wdata_nxt = '0;
          done_i_nxt    = !owner_d;
          done_d_nxt    = owner_d;
          if (mem_ack) begin
            rdata_nxt = mem_we ? '0 : mem_rdata;
          end else begin
            err_nxt        = 1'b1;
            err_sticky_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_d     <= 1'b1;
      owner_d    <= 1'b0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done_i     <= 1'b0;
      done_d     <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_d     <= last_d_nxt;
      owner_d    <= owner_d_nxt;
      busy       <= busy_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      done_i     <= done_i_nxt;
      done_d     <= done_d_nxt;
      rdata      <= rdata_nxt;
      err        <= err_nxt;
      err_sticky <= err_sticky_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed-priority instance (TIMEOUT=15) and
// round-robin instance (TIMEOUT=4), directed vectors plus a randomized model check.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst[2], req_i[2], req_d[2], we_d[2], mem_ack[2];
  logic [AW-1:0] addr_i[2], addr_d[2], mem_addr[2];
  logic [DW-1:0] wdata_d[2], mem_rdata[2], rdata[2], mem_wdata[2];
  logic          gnt_i[2], gnt_d[2], done_i[2], done_d[2], err[2], err_sticky[2];
  logic          busy[2], mem_en[2], mem_we[2];

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(15)) u_fix (
    .clk(clk), .rst(rst[0]),
    .req_i(req_i[0]), .addr_i(addr_i[0]),
    .req_d(req_d[0]), .addr_d(addr_d[0]), .we_d(we_d[0]), .wdata_d(wdata_d[0]),
    .gnt_i(gnt_i[0]), .gnt_d(gnt_d[0]), .done_i(done_i[0]), .done_d(done_d[0]),
    .rdata(rdata[0]), .err(err[0]), .err_sticky(err_sticky[0]), .busy(busy[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0])
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(4)) u_rr (
    .clk(clk), .rst(rst[1]),
    .req_i(req_i[1]), .addr_i(addr_i[1]),
    .req_d(req_d[1]), .addr_d(addr_d[1]), .we_d(we_d[1]), .wdata_d(wdata_d[1]),
    .gnt_i(gnt_i[1]), .gnt_d(gnt_d[1]), .done_i(done_i[1]), .done_d(done_d[1]),
    .rdata(rdata[1]), .err(err[1]), .err_sticky(err_sticky[1]), .busy(busy[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1])
  );

  typedef struct {
    bit          port_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          k;        // BUSY cycle carrying mem_ack, 0 = never
    logic [15:0] mrd;
    int          exp_done; // cycles from grant to done pulse
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs(input int u);
    req_i[u] = 1'b0; addr_i[u] = '0;
    req_d[u] = 1'b0; addr_d[u] = '0; we_d[u] = 1'b0; wdata_d[u] = '0;
    mem_ack[u] = 1'b0; mem_rdata[u] = '0;
  endtask

  task automatic do_reset(input int u);
    @(negedge clk);
    idle_inputs(u);
    rst[u] = 1'b1;
    @(negedge clk);
    rst[u] = 1'b0;
    #1;
    chk("rst_busy", busy[u], 0);       chk("rst_mem_en", mem_en[u], 0);
    chk("rst_mem_we", mem_we[u], 0);   chk("rst_mem_addr", mem_addr[u], 0);
    chk("rst_mem_wdata", mem_wdata[u], 0);
    chk("rst_gnt_i", gnt_i[u], 0);     chk("rst_gnt_d", gnt_d[u], 0);
    chk("rst_done_i", done_i[u], 0);   chk("rst_done_d", done_d[u], 0);
    chk("rst_rdata", rdata[u], 0);     chk("rst_err", err[u], 0);
    chk("rst_err_sticky", err_sticky[u], 0);
  endtask

  // Directed single accesses on the fixed-priority instance
  task automatic run_table();
    bit sticky = 1'b0;
    do_reset(0);
    for (int i = 0; i < 6; i++) begin
      vec_t v = tbl[i];
      @(negedge clk);
      req_i[0]   = !v.port_d;
      addr_i[0]  = v.port_d ? 16'($urandom) : v.addr;
      req_d[0]   = v.port_d;
      addr_d[0]  = v.port_d ? v.addr : 16'($urandom);
      we_d[0]    = v.port_d ? v.we : 1'b1;
      wdata_d[0] = v.port_d ? v.wdata : 16'hA5A5;
      mem_ack[0] = 1'b0;
      #1;
      chk("tbl_gnt_d", gnt_d[0], v.port_d);
      chk("tbl_gnt_i", gnt_i[0], !v.port_d);
      chk("tbl_busy0", busy[0], 0);
      for (int c = 1; c <= v.exp_done + 1; c++) begin
        @(negedge clk);
        req_i[0] = 1'b0; req_d[0] = 1'b0;
        addr_i[0] = 16'($urandom); addr_d[0] = 16'($urandom);
        we_d[0] = 1'($urandom); wdata_d[0] = 16'($urandom);
        mem_ack[0]   = (c == v.k) || (c == v.exp_done);
        mem_rdata[0] = (c == v.k) ? v.mrd : 16'($urandom);
        #1;
        if (c < v.exp_done) begin
          chk("tbl_mem_en", mem_en[0], 1);
          chk("tbl_busy", busy[0], 1);
          chk("tbl_mem_addr", mem_addr[0], v.addr);
          chk("tbl_mem_we", mem_we[0], v.port_d && v.we);
          chk("tbl_mem_wdata", mem_wdata[0], v.port_d ? v.wdata : 16'h0);
          chk("tbl_done_early", done_i[0] | done_d[0], 0);
          chk("tbl_gnt_busy", gnt_i[0] | gnt_d[0], 0);
        end else if (c == v.exp_done) begin
          if (v.exp_err) sticky = 1'b1;
          chk("tbl_mem_en_off", mem_en[0], 0);
          chk("tbl_done_d", done_d[0], v.port_d);
          chk("tbl_done_i", done_i[0], !v.port_d);
          chk("tbl_rdata", rdata[0], v.exp_rd);
          chk("tbl_err", err[0], v.exp_err);
          chk("tbl_err_sticky", err_sticky[0], sticky);
        end else begin
          chk("tbl_idle_busy", busy[0], 0);
          chk("tbl_idle_done", done_i[0] | done_d[0], 0);
          chk("tbl_idle_rdata", rdata[0], 0);
          chk("tbl_idle_err", err[0], 0);
          chk("tbl_idle_sticky", err_sticky[0], sticky);
        end
      end
    end
    idle_inputs(0);
  endtask

  // Both requesters held, one-cycle ack; exp_d_mask bit a = D expected for access a
  task automatic run_contention(input int u, input int n_acc, input bit [7:0] exp_d_mask,
                                input bit [7:0] drop_d_mask, input string tag);
    do_reset(u);
    for (int a = 0; a < n_acc; a++) begin
      bit ed = exp_d_mask[a];
      @(negedge clk);
      req_i[u] = 1'b1; req_d[u] = !drop_d_mask[a];
      addr_i[u] = 16'h1000 + 16'(a); addr_d[u] = 16'h2000 + 16'(a);
      we_d[u] = 1'b0; mem_ack[u] = 1'b0;
      #1;
      chk({tag, "_gnt_d"}, gnt_d[u], ed);
      chk({tag, "_gnt_i"}, gnt_i[u], !ed);
      @(negedge clk);
      mem_ack[u] = 1'b1; mem_rdata[u] = 16'h7000 + 16'(a);
      #1;
      chk({tag, "_busy_gnt"}, gnt_i[u] | gnt_d[u], 0);
      chk({tag, "_mem_addr"}, mem_addr[u], ed ? 16'h2000 + 16'(a) : 16'h1000 + 16'(a));
      @(negedge clk);
      mem_ack[u] = 1'b0;
      #1;
      chk({tag, "_done_d"}, done_d[u], ed);
      chk({tag, "_done_i"}, done_i[u], !ed);
      chk({tag, "_rdata"}, rdata[u], 16'h7000 + 16'(a));
    end
    idle_inputs(u);
  endtask

  task automatic run_reset_mid();
    do_reset(0);
    @(negedge clk);
    req_i[0] = 1'b1; addr_i[0] = 16'h3000;
    #1;
    chk("rm_gnt_i", gnt_i[0], 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      req_i[0] = 1'b0; mem_ack[0] = 1'b0;
      if (c == 3) rst[0] = 1'b1;
      #1;
      chk("rm_mem_en", mem_en[0], 1);
    end
    @(negedge clk);
    rst[0] = 1'b0; mem_ack[0] = 1'b1; mem_rdata[0] = 16'h9999;
    #1;
    chk("rm_busy_off", busy[0], 0);
    chk("rm_mem_en_off", mem_en[0], 0);
    chk("rm_no_done", done_i[0] | done_d[0], 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ack[0] = (c == 0);
      #1;
      chk("rm_late_done", done_i[0] | done_d[0], 0);
      chk("rm_late_busy", busy[0], 0);
    end
    @(negedge clk);
    req_i[0] = 1'b1; addr_i[0] = 16'h3002; mem_ack[0] = 1'b0;
    #1;
    chk("rm_regrant", gnt_i[0], 1);
    @(negedge clk);
    req_i[0] = 1'b0; mem_ack[0] = 1'b1; mem_rdata[0] = 16'h4444;
    #1;
    chk("rm_mem_addr", mem_addr[0], 16'h3002);
    @(negedge clk);
    mem_ack[0] = 1'b0;
    #1;
    chk("rm_done_i", done_i[0], 1);
    chk("rm_rdata", rdata[0], 16'h4444);
    idle_inputs(0);
  endtask

  // Random traffic against a transaction-timeline model: an access granted at
  // cycle g with ack delay k occupies n=min(k,tmo) memory cycles, done at g+n+1.
  task automatic run_random(input int u, input int ncyc, input int tmo, input bit rr);
    bit          pend[2];
    logic [15:0] paddr[2], pwd[2];
    bit          pwe[2];
    int          g = -100, n = 0, k = 0, win;
    bit          owner = 1'b0, last_d = 1'b1, sticky = 1'b0, exp_err = 1'b0;
    logic [15:0] exp_rd = '0, o_addr = '0, o_wd = '0;
    bit          o_we = 1'b0, active, is_done, idle;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; paddr[p] = '0; pwd[p] = '0; pwe[p] = 1'b0;
    end
    do_reset(u);
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 3) == 0) begin
          pend[p]  = 1'b1;
          paddr[p] = 16'($urandom);
          pwe[p]   = (p == 1) && ($urandom_range(0, 1) == 1);
          pwd[p]   = 16'($urandom);
        end
      end
      req_i[u] = pend[0]; addr_i[u] = paddr[0];
      req_d[u] = pend[1]; addr_d[u] = paddr[1]; we_d[u] = pwe[1]; wdata_d[u] = pwd[1];
      active  = (t > g) && (t <= g + n);
      is_done = (t == g + n + 1);
      idle    = (t > g + n + 1);
      mem_rdata[u] = 16'($urandom);
      mem_ack[u]   = 1'b0;
      if (active) begin
        if (t == g + k) begin
          mem_ack[u] = 1'b1;
          exp_rd = o_we ? 16'h0 : mem_rdata[u];
        end
      end else begin
        mem_ack[u] = ($urandom_range(0, 2) == 0);
      end
      if (is_done && exp_err) sticky = 1'b1;
      win = -1;
      if (idle) begin
        if (pend[0] && pend[1]) win = (rr && last_d) ? 0 : 1;
        else if (pend[1])       win = 1;
        else if (pend[0])       win = 0;
      end
      #1;
      chk("rnd_gnt_i", gnt_i[u], win == 0);
      chk("rnd_gnt_d", gnt_d[u], win == 1);
      chk("rnd_busy", busy[u], active || is_done);
      chk("rnd_mem_en", mem_en[u], active);
      if (active) begin
        chk("rnd_mem_addr", mem_addr[u], o_addr);
        chk("rnd_mem_we", mem_we[u], o_we);
        chk("rnd_mem_wdata", mem_wdata[u], o_wd);
      end
      chk("rnd_done_i", done_i[u], is_done && !owner);
      chk("rnd_done_d", done_d[u], is_done && owner);
      chk("rnd_rdata", rdata[u], is_done ? exp_rd : 16'h0);
      chk("rnd_err", err[u], is_done && exp_err);
      chk("rnd_err_sticky", err_sticky[u], sticky);
      if (win >= 0) begin
        owner   = (win == 1);
        last_d  = owner;
        g       = t;
        k       = $urandom_range(1, tmo + 3);
        n       = (k <= tmo) ? k : tmo;
        exp_err = (k > tmo);
        exp_rd  = '0;
        o_addr  = paddr[win];
        o_we    = owner && pwe[1];
        o_wd    = owner ? pwd[1] : 16'h0;
        pend[win] = 1'b0;
      end
    end
    idle_inputs(u);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000,  2, 16'hBEEF,  3, 16'hBEEF, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'h0100, 16'h1234,  3, 16'h5555,  4, 16'h0000, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 16'h0200, 16'h0000,  0, 16'h0000, 16, 16'h0000, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 16'h0202, 16'h0000, 15, 16'hCAFE, 16, 16'hCAFE, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 14, 16'h1357, 15, 16'h1357, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000,  1, 16'hFFFF,  2, 16'hFFFF, 1'b0};

    for (int u = 0; u < 2; u++) begin
      idle_inputs(u);
      rst[u] = 1'b1;
    end
    do_reset(0);
    do_reset(1);

    run_table();
    run_contention(0, 4, 8'b0000_0111, 8'b0000_1000, "fp");
    run_contention(1, 4, 8'b0000_1010, 8'b0000_0000, "rr");
    run_reset_mid();
    run_random(0, 2000, 15, 1'b0);
    run_random(1, 2000, 4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported 16-bit MIPS16 memory between the instruction-fetch requester (port I) and the load/store requester (port D).
- Arbitrates, latches the winning command, holds it on the memory port until acknowledged, then returns completion and read data to the winner.
- Aborts stalled accesses with a timeout error.
- Sits between fetch/LSU stages and the memory model/BRAM wrapper.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- RR_MODE, 0, arbitration policy: 0 = fixed priority with D over I; 1 = round-robin.
- TIMEOUT, 15, max cycles in BUSY without mem_ack before abort (legal range 1..255).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- req_i  in  1  fetch request; held until gnt_i
- addr_i  in  ADDR_W  fetch address
- req_d  in  1  load/store request; held until gnt_d
- addr_d  in  ADDR_W  load/store address
- we_d  in  1  1 = store, 0 = load
- wdata_d  in  DATA_W  store data
- gnt_i  out  1  fetch accepted; combinational, IDLE only
- gnt_d  out  1  load/store accepted; combinational, IDLE only
- done_i  out  1  fetch complete, 1-cycle pulse
- done_d  out  1  load/store complete, 1-cycle pulse
- rdata  out  DATA_W  read data; valid with done_x on reads
- err  out  1  with done_x: access timed out
- err_sticky  out  1  set on any timeout, cleared only by rst
- busy  out  1  state != IDLE
- mem_en  out  1  memory command valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; sampled with mem_ack
- mem_ack  in  1  memory completion

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous, active-high, named rst.
- Reset: rst=1 at a rising edge forces the following, overriding all other activity including mid-transaction:
  - state=IDLE
  - all outputs 0 (busy, mem_en, mem_we, mem_addr, mem_wdata, gnt_*, done_*, rdata, err, err_sticky)
  - timeout counter 0
  - last-grant pointer = D, so I wins the first round-robin tie
  - a pending command is discarded with no done pulse.
- States:
  - IDLE: no command outstanding.
  - BUSY: mem_en=1; mem_we, mem_addr and mem_wdata are registered and stable for the whole state.
  - DONE: done_x=1 for exactly one cycle.
- IDLE arbitration:
  - Only one requester high: that one wins.
  - Both high, RR_MODE=0: D wins.
  - Both high, RR_MODE=1: the port not recorded in last-grant wins.
  - The winning gnt_x is asserted combinationally in the same cycle. At that edge the arbiter latches addr, we (0 for I) and wdata (0 for I), records the winner and last-grant, clears the counter and moves to BUSY.
  - The loser sees no gnt and must hold its request.
- BUSY:
  - If mem_ack=1: latch rdata = mem_rdata on a read, 0 on a store; err=0; go to DONE.
  - Else if counter == TIMEOUT-1: rdata=0, err=1, err_sticky=1; go to DONE.
  - Else increment the counter.
  - mem_en deasserts in the cycle after the ack edge.
- DONE: pulse done_x for the recorded winner, with rdata and err valid that cycle. Next state is IDLE; rdata and err return to 0.
- Latency, grant edge to done_x, with ack in the k-th BUSY cycle (k>=1): k+1 cycles. Minimum period per access is 3 cycles (IDLE, BUSY, DONE).
- Ignored inputs: mem_ack in IDLE or DONE has no effect. req_x in BUSY or DONE is not granted. gnt_* is never asserted outside IDLE.
- Exclusivity: at most one of gnt_i/gnt_d and at most one of done_i/done_d is high in any cycle.
- Ack and timeout in the same cycle: the ack wins and err=0.

Test Plan:
- Single load: req_d=1, addr_d=0x0040, we_d=0; memory acks in 2nd BUSY cycle with 0xBEEF -> gnt_d in cycle 0, mem_en high cycles 1-2 with mem_addr=0x0040, done_d and rdata=0xBEEF in cycle 3, err=0.
- Fixed-priority contention (RR_MODE=0): req_i and req_d both held, 1-cycle ack -> grants D,D,D for 3 consecutive accesses while D keeps requesting; I granted only once req_d drops.
- Round-robin (RR_MODE=1): both held continuously after reset -> grants alternate I,D,I,D; each done matches its grant.
- Store: req_d=1, we_d=1, addr_d=0x0100, wdata_d=0x1234 -> mem_we=1 and mem_wdata=0x1234 stable throughout BUSY; done_d with rdata=0x0000.
- Timeout (TIMEOUT=15): grant I, never ack -> mem_en high exactly 15 cycles; done_i with err=1 and rdata=0; err_sticky=1 and stays 1 until rst; next request is served normally.
- Reset mid-operation: rst=1 in 3rd BUSY cycle -> next cycle busy=0, mem_en=0, no done pulse ever; a late mem_ack is ignored; a subsequent req_i is granted immediately.
